flopr_pipe: RTL and testbench

Parametrised elastic pipeline register: a chain of DEPTH flopr-style stages, each N bits wide, with a per-stage valid bit, valid/ready handshake on both ends, bubble collapsing, synchronous flush and an occupancy counter. It is the successor to the plain reset flip-flop and sits between datapath pipeline stages. It is also used as a short in-order buffer wherever a producer and a consumer must be decoupled under back-pressure.

---
 rtl/flopr_pipe_if.sv | 28 ++
 rtl/flopr_pipe.sv | 88 ++++++++
 tb/tb_flopr_pipe.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flopr_pipe_if.sv
// Handshake bundle for flopr_pipe: producer side (in_*, d), consumer side (out_*, q)
// and the occupancy count.
interface flopr_pipe_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 3
) ();
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  d;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  q;
    logic [CW-1:0] count;

    // Environment side: drives the producer data and consumer ready.
    modport master (
        output in_valid, d, out_ready,
        input  in_ready, out_valid, q, count
    );

    // Pipeline side.
    modport slave (
        input  in_valid, d, out_ready,
        output in_ready, out_valid, q, count
    );
endinterface

// File: rtl/flopr_pipe.sv
// Elastic pipeline register: DEPTH valid-tagged stages with a combinational ready chain,
// bubble collapsing, synchronous flush and a registered occupancy counter.
module flopr_pipe #(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    flopr_pipe_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][N-1:0] data_q, data_d, up_data;
    logic [DEPTH-1:0]        v_q, v_d, up_valid, rdy;
    logic [CW-1:0]           count_q, count_d;
    logic                    in_ready, in_xfer, out_xfer;

    // rdy[i] is high when any stage at or after i is empty, or the sink is taking q.
    always_comb begin : ready_chain
        logic acc;
        rdy = '0;
        acc = bus.out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            acc    = acc | ~v_q[i];
            rdy[i] = acc;
        end
    end

    always_comb begin
        up_valid    = '0;
        up_data     = '0;
        up_valid[0] = bus.in_valid;
        up_data[0]  = bus.d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            up_valid[i] = v_q[i-1];
            up_data[i]  = data_q[i-1];
        end
    end

    // A ready stage takes its upstream valid; data is only replaced by valid data.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
                v_d[i] = up_valid[i];
                if (up_valid[i]) begin
                    data_d[i] = up_data[i];
                end
            end
        end
    end

    assign in_ready = rdy[0] & ~flush;
    assign in_xfer  = bus.in_valid & in_ready;
    assign out_xfer = v_q[DEPTH-1] & bus.out_ready;

    always_comb begin
        count_d = count_q;
        if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q     <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            v_q     <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.q         = data_q[DEPTH-1];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_flopr_pipe.sv
// Directed and randomized checks of flopr_pipe against a queue-of-items model in which each
// item advances one slot per edge until it is blocked by the item ahead of it.
module tb_flopr_pipe;
    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 3;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    flopr_pipe_if #(.N(N), .DEPTH(DEPTH)) bus ();

    flopr_pipe #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mdata[$];  // items in the pipe, oldest first
    int mpos[$];   // slot of each item, DEPTH-1 is the output slot
    int got[$];    // items taken by the sink

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_in_ready();
        return !flush && ((mdata.size() < int'(DEPTH)) || (bus.out_ready == 1'b1));
    endfunction

    function automatic bit m_out_valid();
        return (mdata.size() > 0) && (mpos[0] == int'(DEPTH) - 1);
    endfunction

    task automatic check_all();
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_out_valid()));
        chk("count", 32'(bus.count), 32'(mdata.size()));
        if (m_out_valid()) chk("q", 32'(bus.q), 32'(mdata[0]));
    endtask

    task automatic model_edge();
        bit ix, ox;
        ix = bus.in_valid && m_in_ready();
        ox = m_out_valid() && bus.out_ready;
        if (bus.out_valid && bus.out_ready) got.push_back(int'(bus.q));
        if (flush) begin
            mdata.delete();
            mpos.delete();
        end else begin
            if (ox) begin
                void'(mdata.pop_front());
                void'(mpos.pop_front());
            end
            for (int k = 0; k < mpos.size(); k++) begin
                int lim;
                int np;
                lim = (k == 0) ? int'(DEPTH) - 1 : mpos[k-1] - 1;
                np  = mpos[k] + 1;
                if (np > lim) np = lim;
                mpos[k] = np;
            end
            if (ix) begin
                mdata.push_back(int'(bus.d));
                mpos.push_back(0);
            end
        end
    endtask

    task automatic tick();
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bit acc;
        bus.in_valid = 1'b1;
        bus.d        = N'(v);
        for (int i = 0; i < 20; i++) begin
            acc = m_in_ready();
            tick();
            if (acc) return;
        end
        total++;
        bad++;
        $error("FAIL send_timeout: observed=not_accepted expected=accepted value=%0h", v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pending;
        bit acc;

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.d         = '0;
        bus.out_ready = 1'b0;
        #2 reset = 1'b0;
        #2;
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        // Edges while reset is held must not load anything.
        bus.in_valid = 1'b1;
        bus.d        = 4'h5;
        @(posedge clk);
        #1;
        chk("rst_hold_count", 32'(bus.count), 32'd0);
        chk("rst_hold_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1;

        // Stream 1..15 with the sink always ready.
        got.delete();
        bus.out_ready = 1'b1;
        for (int v = 1; v <= 15; v++) send(v);
        bus.in_valid = 1'b0;
        repeat (DEPTH + 2) tick();
        chk("stream_len", 32'(got.size()), 32'd15);
        for (int i = 0; i < got.size(); i++) chk("stream_order", 32'(got[i]), 32'(i + 1));

        // Back-pressure: 5,6,7 fill the pipe, 8 waits.
        got.delete();
        bus.out_ready = 1'b0;
        send(5);
        send(6);
        send(7);
        bus.in_valid = 1'b1;
        bus.d        = 4'h8;
        #1;
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_count", 32'(bus.count), 32'd3);
        chk("bp_q", 32'(bus.q), 32'd5);
        tick();
        tick();
        chk("bp_q_stable", 32'(bus.q), 32'd5);
        bus.out_ready = 1'b1;
        send(8);
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("bp_len", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size(); i++) chk("bp_order", 32'(got[i]), 32'(i + 5));
        chk("bp_count_end", 32'(bus.count), 32'd0);

        // Bubble collapse under a stalled sink.
        got.delete();
        bus.out_ready = 1'b0;
        send(9);
        bus.in_valid = 1'b0;
        tick();
        tick();
        send(10);
        bus.in_valid = 1'b0;
        #1;
        chk("bub_count2", 32'(bus.count), 32'd2);
        chk("bub_q", 32'(bus.q), 32'd9);
        send(11);
        bus.in_valid = 1'b0;
        #1;
        chk("bub_count3", 32'(bus.count), 32'd3);

        // Full pipe with simultaneous input and output transfer.
        bus.in_valid  = 1'b1;
        bus.d         = 4'hD;
        bus.out_ready = 1'b1;
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("full_count", 32'(bus.count), 32'd3);
        chk("full_emitted", 32'(got.size() > 0 ? got[0] : -1), 32'd9);

        // Flush with two items held and C offered.
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("fl_pre_count", 32'(bus.count), 32'd2);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.d        = 4'hC;
        #1;
        chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("fl_count", 32'(bus.count), 32'd0);
        chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_q", 32'(bus.q), 32'd0);
        got.delete();
        bus.out_ready = 1'b1;
        repeat (5) tick();
        chk("fl_nothing_out", 32'(got.size()), 32'd0);

        // Asynchronous reset in the middle of a cycle with a full pipe.
        bus.out_ready = 1'b0;
        send(1);
        send(2);
        send(3);
        bus.in_valid = 1'b0;
        #1;
        chk("ar_pre_count", 32'(bus.count), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("ar_q", 32'(bus.q), 32'd0);
        chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_count", 32'(bus.count), 32'd0);
        chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
        mdata.delete();
        mpos.delete();
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic; a stalled offer is held until taken.
        pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                bus.in_valid = ($urandom_range(0, 9) < 6);
                bus.d        = N'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 1) == 1);
            flush         = ($urandom_range(0, 29) == 0);
            acc           = m_in_ready();
            pending       = bus.in_valid && !acc;
            tick();
        end
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("rand_drained", 32'(bus.count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
